// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit between EXU and WBU: one request in flight, valid/ready bus with
// response timeout, misalignment detection, store lane replication and load extension.
module ysyx_25020047_lsu #(
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        ld_en,
   input  logic        st_en,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] st_data,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        mem_wen,
   output logic [3:0]  mem_wmask,
   output logic [31:0] mem_wdata,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] memdata,
   output logic        fault
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    f3;
   logic [1:0]    lane;
   logic          is_st;

   logic          misaligned;
   logic [3:0]    st_mask;
   logic [31:0]   st_word;
   logic [7:0]    b_lane;
   logic [15:0]   h_lane;
   logic [31:0]   ld_data;

   assign in_ready   = (state == IDLE);
   assign misaligned = (funct3[1:0] == 2'b01 && addr[0]) ||
                       (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);

   always_comb begin
      st_mask = 4'b1111;
      st_word = st_data;
      case (funct3[1:0])
         2'b00: begin
            st_mask = 4'b0001 << addr[1:0];
            st_word = {4{st_data[7:0]}};
         end
         2'b01: begin
            st_mask = 4'b0011 << {addr[1], 1'b0};
            st_word = {2{st_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Extraction uses the latched lane/width, since the EXU inputs have moved on by WAIT.
   always_comb begin
      case (lane)
         2'd1:    b_lane = mem_rdata[15:8];
         2'd2:    b_lane = mem_rdata[23:16];
         2'd3:    b_lane = mem_rdata[31:24];
         default: b_lane = mem_rdata[7:0];
      endcase
      h_lane = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3)
         3'b000:  ld_data = {{24{b_lane[7]}}, b_lane};
         3'b100:  ld_data = {24'b0, b_lane};
         3'b001:  ld_data = {{16{h_lane[15]}}, h_lane};
         3'b101:  ld_data = {16'b0, h_lane};
         default: ld_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         f3            <= 3'b0;
         lane          <= 2'b0;
         is_st         <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_addr      <= 32'b0;
         mem_wen       <= 1'b0;
         mem_wmask     <= 4'b0;
         mem_wdata     <= 32'b0;
         out_valid     <= 1'b0;
         memdata       <= 32'b0;
         fault         <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               f3    <= funct3;
               lane  <= addr[1:0];
               is_st <= st_en;
               if (!(ld_en || st_en) || misaligned) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  memdata   <= 32'b0;
                  fault     <= (ld_en || st_en);
               end else begin
                  state         <= REQ;
                  mem_req_valid <= 1'b1;
                  mem_addr      <= {addr[31:2], 2'b00};
                  mem_wen       <= st_en;
                  mem_wmask     <= st_en ? st_mask : 4'b0;
                  mem_wdata     <= st_en ? st_word : 32'b0;
               end
            end
            REQ: if (mem_req_ready) begin
               state         <= WAIT;
               cnt           <= '0;
               mem_req_valid <= 1'b0;
               mem_wen       <= 1'b0;
               mem_wmask     <= 4'b0;
            end
            WAIT: begin
               if (mem_resp_valid) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  memdata   <= is_st ? 32'b0 : ld_data;
                  fault     <= 1'b0;
               end else if (cnt == LAST) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  memdata   <= 32'b0;
                  fault     <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: if (out_ready) begin
               state     <= IDLE;
               out_valid <= 1'b0;
               memdata   <= 32'b0;
               fault     <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Bench for ysyx_25020047_lsu: directed spec cases then randomized transactions,
// each checked against an arithmetic model of width/lane/extension rules.
module tb_ysyx_25020047_lsu;

   localparam int TIMEOUT = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, ld_en, st_en;
   logic [2:0]  funct3;
   logic [31:0] addr, st_data;
   logic        mem_req_valid, mem_req_ready, mem_wen;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, memdata;
   logic [3:0]  mem_wmask;
   logic        mem_resp_valid, out_valid, out_ready, fault;

   int total  = 0;
   int passed = 0;

   ysyx_25020047_lsu #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .ld_en(ld_en), .st_en(st_en), .funct3(funct3),
      .addr(addr), .st_data(st_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .memdata(memdata), .fault(fault)
   );

   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL watchdog: observed no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h required %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One full transaction. sdly < 0 means the bus never answers (timeout expected).
   task automatic txn(input logic ld, input logic st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                      input int rdly, input int sdly);
      int size, lat, m, n, hold;
      logic mis, bus, ef;
      logic [3:0] emask;
      logic [31:0] ewdata, raw, emem, held;
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      mis  = (ld || st) && (a % size != 0);
      bus  = (ld || st) && !mis;
      m = ((1 << size) - 1) << (a % 4);
      emask = m[3:0];
      for (int i = 0; i < 4; i++) ewdata[8*i +: 8] = sd[8*(i % size) +: 8];
      raw = rd >> (8 * (a % 4));
      if (size == 1) raw = raw & 32'hFF;
      if (size == 2) raw = raw & 32'hFFFF;
      if (!f3[2] && size < 4 && raw[8*size-1]) raw = raw | ~((32'h1 << (8*size)) - 1);
      emem = (bus && !st && sdly >= 0) ? raw : 32'h0;
      ef   = mis || (bus && sdly < 0);

      @(negedge clk);
      chk("in_ready_idle", in_ready, 1);
      in_valid = 1; ld_en = ld; st_en = st; funct3 = f3; addr = a; st_data = sd;
      @(posedge clk);
      @(negedge clk);
      lat = 1;
      in_valid = 0; ld_en = $urandom; st_en = $urandom; funct3 = 3'($urandom);
      addr = $urandom; st_data = $urandom;
      if (bus) begin
         for (int k = 0; k <= rdly; k++) begin
            chk("req_valid", mem_req_valid, 1);
            chk("req_addr", mem_addr, {a[31:2], 2'b00});
            chk("req_wen", mem_wen, st);
            chk("req_wmask", mem_wmask, st ? emask : 4'b0);
            if (st) chk("req_wdata", mem_wdata, ewdata);
            mem_req_ready = (k == rdly);
            step(); lat++;
         end
         mem_req_ready = 0;
         chk("req_dropped", mem_req_valid, 0);
         if (sdly >= 0) begin
            for (int k = 0; k < sdly; k++) begin
               chk("wait_no_out", out_valid, 0);
               step(); lat++;
            end
            mem_resp_valid = 1; mem_rdata = rd;
            step(); lat++;
            mem_resp_valid = 0; mem_rdata = $urandom;
            chk("latency", lat, 3 + rdly + sdly);
         end else begin
            n = 0;
            while (!out_valid && n < 2000) begin step(); n++; end
            chk("timeout_cycles", n, TIMEOUT);
         end
      end else begin
         chk("no_bus_req", mem_req_valid, 0);
         chk("latency_short", lat, 1);
      end
      chk("out_valid", out_valid, 1);
      chk("memdata", memdata, emem);
      chk("fault", fault, ef);
      chk("in_ready_done", in_ready, 0);
      held = memdata;
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
         mem_resp_valid = 1; mem_rdata = $urandom;
         step();
         chk("hold_valid", out_valid, 1);
         chk("hold_memdata", memdata, held);
      end
      mem_resp_valid = 0;
      out_ready = 1;
      step();
      out_ready = 0;
      chk("back_idle", in_ready, 1);
      chk("out_cleared", out_valid, 0);
   endtask

   initial begin
      logic [2:0] f3s [5];
      logic [2:0] f3r;
      int kind;
      f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      rst = 1; in_valid = 0; ld_en = 0; st_en = 0; funct3 = 0; addr = 0; st_data = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0; out_ready = 0;
      step(); step();
      rst = 0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_req_valid", mem_req_valid, 0);
      chk("rst_wen", mem_wen, 0);
      chk("rst_wmask", mem_wmask, 0);
      chk("rst_fault", fault, 0);
      chk("rst_memdata", memdata, 0);

      txn(1, 0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0);  // lb sign
      txn(0, 1, 3'b001, 32'h8000_0102, 32'h0000_ABCD, 32'h0, 0, 0);  // sh upper half
      txn(1, 0, 3'b010, 32'h8000_0002, 32'h0, 32'h0, 0, 0);          // lw misaligned
      txn(1, 0, 3'b101, 32'h8000_0002, 32'h0, 32'h9ABC_0000, 5, 0);  // lhu, slow ready
      txn(0, 0, 3'b010, 32'h8000_0001, 32'h0, 32'h0, 0, 0);          // non-memory
      txn(0, 1, 3'b010, 32'h8000_0003, 32'h1234_5678, 32'h0, 0, 0);  // sw misaligned
      txn(1, 0, 3'b010, 32'h8000_0010, 32'h0, 32'h0, 0, -1);         // timeout

      // Reset while waiting for a response; a late response must be dropped.
      @(negedge clk);
      in_valid = 1; ld_en = 1; st_en = 0; funct3 = 3'b010; addr = 32'h8000_0020;
      step();
      in_valid = 0; mem_req_ready = 1;
      step();
      mem_req_ready = 0;
      rst = 1;
      step();
      rst = 0;
      chk("wrst_in_ready", in_ready, 1);
      chk("wrst_out_valid", out_valid, 0);
      step(); step();
      mem_resp_valid = 1; mem_rdata = 32'hDEAD_BEEF;
      step();
      mem_resp_valid = 0;
      for (int k = 0; k < 3; k++) begin
         chk("late_resp_out", out_valid, 0);
         chk("late_resp_ready", in_ready, 1);
         step();
      end

      // Reset while a request is pending in REQ.
      in_valid = 1; ld_en = 0; st_en = 1; funct3 = 3'b000; addr = 32'h8000_0031;
      step();
      in_valid = 0;
      chk("req_pending", mem_req_valid, 1);
      rst = 1;
      step();
      rst = 0;
      chk("rrst_req_valid", mem_req_valid, 0);
      chk("rrst_wmask", mem_wmask, 0);
      chk("rrst_in_ready", in_ready, 1);

      for (int t = 0; t < 60; t++) begin
         f3r  = f3s[$urandom_range(0, 4)];
         kind = $urandom_range(0, 9);
         if (kind == 0)
            txn(0, 0, f3r, $urandom, $urandom, $urandom, 0, 0);
         else if (kind <= 4)
            txn(0, 1, f3r & 3'b011, 32'h8000_0000 | ($urandom & 32'hFFFF),
                $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
         else
            txn(1, 0, f3r, 32'h8000_0000 | ($urandom & 32'hFFFF),
                $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ysyx_25020047_lsu.md
YSYX_25020047_LSU -- requirements
Module: ysyx_25020047_LSU

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: number of WAIT-state cycles without a response before a bus fault is raised.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1: EXU presents a request.
REQ-005 SHALL have port in_ready, output, 1: LSU accepts a request; high only in IDLE.
REQ-006 SHALL have port ld_en, input, 1: request is a load.
REQ-007 SHALL have port st_en, input, 1: request is a store.
REQ-008 SHALL have port funct3, input, 3: RISC-V width code (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-009 SHALL have port addr, input, 32: effective address from EXU result.
REQ-010 SHALL have port st_data, input, 32: rs2 value for stores.
REQ-011 SHALL have port mem_req_valid, output, 1: bus request valid.
REQ-012 SHALL have port mem_req_ready, input, 1: bus accepts the request.
REQ-013 SHALL have port mem_addr, output, 32: word-aligned address {addr[31:2],2'b00}.
REQ-014 SHALL have port mem_wen, output, 1: bus write.
REQ-015 SHALL have port mem_wmask, output, 4: byte-lane strobe.
REQ-016 SHALL have port mem_wdata, output, 32: lane-replicated store data.
REQ-017 SHALL have port mem_resp_valid, input, 1: read data or write acknowledge.
REQ-018 SHALL have port mem_rdata, input, 32: raw read word.
REQ-019 SHALL have port out_valid, output, 1: result to WBU valid.
REQ-020 SHALL have port out_ready, input, 1: WBU consumes the result.
REQ-021 SHALL have port memdata, output, 32: extended load data to WBU.
REQ-022 SHALL have port fault, output, 1: misaligned access or bus timeout; valid with out_valid.

Function
REQ-023 SHALL implement FSM IDLE -> REQ -> WAIT -> DONE -> IDLE, with all outputs driven from registers or state.
REQ-024 SHALL, in IDLE on in_valid, latch addr, funct3, ld_en, st_en and st_data, then go to REQ, or to DONE when neither ld_en nor st_en is set (memdata=0, fault=0).
REQ-025 SHALL detect misalignment at acceptance: h/hu with addr[0]=1, or w with addr[1:0]!=0. Such a request skips the bus, goes straight to DONE with fault=1 and memdata=0, and never asserts mem_req_valid.
REQ-026 SHALL hold mem_req_valid high in REQ, with mem_addr, mem_wen, mem_wmask and mem_wdata stable, until mem_req_ready; the state then becomes WAIT.
REQ-027 SHALL build store masks and data as follows:
- sb: wmask = 0001<<addr[1:0], wdata = {4{st_data[7:0]}}
- sh: wmask = 0011<<{addr[1],1'b0}, wdata = {2{st_data[15:0]}}
- sw: wmask = 1111, wdata = st_data
REQ-028 SHALL drive mem_wmask = 0000 and mem_wen = 0 for loads.
REQ-029 SHALL, in WAIT, count cycles from 0. On mem_resp_valid it registers the result and enters DONE with fault=0; when the count reaches TIMEOUT-1 without a response it enters DONE with fault=1 and memdata=0.
REQ-030 SHALL extract load data as follows:
- lb/lbu: byte at lane addr[1:0], sign- or zero-extended
- lh/lhu: halfword at lane addr[1], sign- or zero-extended
- lw: full word
REQ-031 SHALL return memdata=0 for stores.
REQ-032 SHALL hold out_valid, memdata and fault stable in DONE until out_ready, then return to IDLE; in_ready is low in DONE, so back-to-back requests are never accepted in the same cycle.
REQ-033 SHALL ignore mem_resp_valid outside WAIT.
REQ-034 SHALL give minimum latency, with ready and response immediate, of out_valid high 3 cycles after the accept edge for bus accesses and 1 cycle after for misaligned or non-memory requests.
REQ-035 SHALL clear the timeout counter on every entry to WAIT; the counter is wide enough for TIMEOUT without wrap.

Reset
REQ-036 SHALL, on a rising edge with rst=1, enter IDLE from any state (including mid-REQ or mid-WAIT) and clear mem_req_valid, mem_wen, mem_wmask, out_valid, fault, memdata and the counter to 0, giving in_ready=1 in the following cycle.
REQ-037 SHALL drop a bus response arriving after a reset that aborted WAIT, with no out_valid generated.

Verification
REQ-038 SHALL cover lb at addr 0x80000003 with mem_rdata 0x80FF1234 -> mem_addr 0x80000000, memdata 0xFFFFFF80, fault 0.
REQ-039 SHALL cover sh at addr 0x80000102 with st_data 0x0000ABCD -> mem_wmask 1100, mem_wdata 0xABCDABCD, mem_wen 1, memdata 0.
REQ-040 SHALL cover lw at addr 0x80000002 -> no mem_req_valid, out_valid 1 cycle after accept, fault 1.
REQ-041 SHALL cover lhu at 0x80000002 with mem_req_ready held low 5 cycles and rdata 0x9ABC0000 -> request held stable 5 cycles, memdata 0x00009ABC.
REQ-042 SHALL cover a load with no response for TIMEOUT (1024) cycles -> fault 1, memdata 0, then return to IDLE after out_ready.
REQ-043 SHALL cover rst asserted in WAIT, then mem_resp_valid 2 cycles later -> IDLE, out_valid stays 0, in_ready 1.
